// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and encodings for the CPU controller slice: FSM state enum,
// instruction opcode/op field values, ALU operation codes and the one-hot
// write-data select codes driven onto vsel.
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WIMM   = 3'd2,
        S_GETA   = 3'd3,
        S_GETB   = 3'd4,
        S_EXEC   = 3'd5,
        S_WREG   = 3'd6
    } state_t;

    // opcode field IR[15:13]
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // op field IR[12:11], meaning depends on opcode
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam logic [3:0] VSEL_C     = 4'b0001;
    localparam logic [3:0] VSEL_PC    = 4'b0010;
    localparam logic [3:0] VSEL_IMM8  = 4'b0100;
    localparam logic [3:0] VSEL_MDATA = 4'b1000;

endpackage : cpu_pkg

// File: rtl/cpu_controller_if.sv
// -----------------------------------------------------------------------------
// cpu_dp_if
// Datapath control bundle between the controller (master, issues strobes)
// and the register-file/ALU datapath (slave, consumes them).
//   readnum/writenum : register-file read/write index
//   write            : register-file write enable
//   loada/loadb/loadc/loads : A, B, C and status register loads
//   asel/bsel        : ALU operand selects
//   shift/ALUop      : shifter and ALU control
//   vsel             : one-hot write-data select
//   sximm8/sximm5    : sign-extended immediates from the IR
// -----------------------------------------------------------------------------
interface cpu_dp_if;

    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic        loadc;
    logic        loads;
    logic [3:0]  vsel;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    modport master (
        output readnum, writenum, write, loada, loadb, asel, bsel,
               shift, ALUop, loadc, loads, vsel, sximm8, sximm5
    );

    modport slave (
        input  readnum, writenum, write, loada, loadb, asel, bsel,
               shift, ALUop, loadc, loads, vsel, sximm8, sximm5
    );

endinterface : cpu_dp_if

// File: rtl/instr_dec.sv
// -----------------------------------------------------------------------------
// instr_dec
// Purely combinational field extraction from the instruction register.
//   i_ir       : latched instruction word
//   o_opcode   : IR[15:13]       o_op : IR[12:11]
//   o_rn       : IR[10:8]        o_rd : IR[7:5]
//   o_sh       : IR[4:3]         o_rm : IR[2:0]
//   o_sximm8   : IR[7:0] sign-extended to 16 bits
//   o_sximm5   : IR[4:0] sign-extended to 16 bits
// -----------------------------------------------------------------------------
module instr_dec
    import cpu_pkg::*;
(
    input  logic [15:0] i_ir,
    output logic [2:0]  o_opcode,
    output logic [1:0]  o_op,
    output logic [2:0]  o_rn,
    output logic [2:0]  o_rd,
    output logic [1:0]  o_sh,
    output logic [2:0]  o_rm,
    output logic [15:0] o_sximm8,
    output logic [15:0] o_sximm5
);

    assign o_opcode = i_ir[15:13];
    assign o_op     = i_ir[12:11];
    assign o_rn     = i_ir[10:8];
    assign o_rd     = i_ir[7:5];
    assign o_sh     = i_ir[4:3];
    assign o_rm     = i_ir[2:0];
    assign o_sximm8 = {{8{i_ir[7]}}, i_ir[7:0]};
    assign o_sximm5 = {{11{i_ir[4]}}, i_ir[4:0]};

endmodule : instr_dec

// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
// Instruction register plus Moore control FSM that sequences the datapath one
// step per cycle and handshakes with a host.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears state and IR
//   in    : instruction word, captured when load=1 while idle
//   load  : IR load request (ignored unless in S_WAIT)
//   s     : start request (ignored unless in S_WAIT)
//   w     : high while idle in S_WAIT
//   dp    : datapath control bundle (master side)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_WAIT   | idle, w=1; accepts load and s
// S_DECODE | classify IR, no strobes; undefined encodings return to idle
// S_WIMM   | write sximm8 into Rn
// S_GETA   | read Rn into A
// S_GETB   | read Rm into B
// S_EXEC   | run shifter/ALU into C, or into status only for CMP
// S_WREG   | write C into Rd
// -----------------------------------------------------------------------------
module cpu_controller
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    cpu_dp_if.master    dp
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;

    logic [2:0]  w_opcode;
    logic [1:0]  w_op;
    logic [2:0]  w_rn;
    logic [2:0]  w_rd;
    logic [1:0]  w_sh;
    logic [2:0]  w_rm;
    logic [15:0] w_sximm8;
    logic [15:0] w_sximm5;

    instr_dec u_dec (
        .i_ir     (r_ir),
        .o_opcode (w_opcode),
        .o_op     (w_op),
        .o_rn     (w_rn),
        .o_rd     (w_rd),
        .o_sh     (w_sh),
        .o_rm     (w_rm),
        .o_sximm8 (w_sximm8),
        .o_sximm5 (w_sximm5)
    );

    assign dp.sximm8 = w_sximm8;
    assign dp.sximm5 = w_sximm5;

    // IR only moves while idle so an instruction in flight sees a stable word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (load && (r_state == S_WAIT))
                r_ir <= in;
        end
    end

    always_comb begin
        w_next      = r_state;
        w           = 1'b0;
        dp.readnum  = 3'd0;
        dp.writenum = 3'd0;
        dp.write    = 1'b0;
        dp.loada    = 1'b0;
        dp.loadb    = 1'b0;
        dp.asel     = 1'b0;
        dp.bsel     = 1'b0;
        dp.shift    = 2'b00;
        dp.ALUop    = ALU_ADD;
        dp.loadc    = 1'b0;
        dp.loads    = 1'b0;
        dp.vsel     = VSEL_C;

        case (r_state)
            S_WAIT: begin
                w = 1'b1;
                if (s)
                    w_next = S_DECODE;
            end

            S_DECODE: begin
                if (w_opcode == OPC_MOV && w_op == OP_MOV_IMM)
                    w_next = S_WIMM;
                else if (w_opcode == OPC_MOV && w_op == OP_MOV_REG)
                    w_next = S_GETB;
                else if (w_opcode == OPC_ALU && w_op == OP_MVN)
                    w_next = S_GETB;
                else if (w_opcode == OPC_ALU)
                    w_next = S_GETA;
                else
                    w_next = S_WAIT;
            end

            S_WIMM: begin
                dp.writenum = w_rn;
                dp.vsel     = VSEL_IMM8;
                dp.write    = 1'b1;
                w_next      = S_WAIT;
            end

            S_GETA: begin
                dp.readnum = w_rn;
                dp.loada   = 1'b1;
                w_next     = S_GETB;
            end

            S_GETB: begin
                dp.readnum = w_rm;
                dp.loadb   = 1'b1;
                w_next     = S_EXEC;
            end

            S_EXEC: begin
                dp.shift = w_sh;
                w_next   = S_WREG;
                // MOV reg reuses the adder with A forced to zero: 0 + (Rm shifted).
                if (w_opcode == OPC_MOV) begin
                    dp.asel  = 1'b1;
                    dp.ALUop = ALU_ADD;
                    dp.loadc = 1'b1;
                end else begin
                    case (w_op)
                        OP_ADD: begin
                            dp.ALUop = ALU_ADD;
                            dp.loadc = 1'b1;
                        end
                        OP_CMP: begin
                            dp.ALUop = ALU_SUB;
                            dp.loads = 1'b1;
                            w_next   = S_WAIT;
                        end
                        OP_AND: begin
                            dp.ALUop = ALU_AND;
                            dp.loadc = 1'b1;
                        end
                        default: begin
                            dp.ALUop = ALU_NOTB;
                            dp.loadc = 1'b1;
                        end
                    endcase
                end
            end

            S_WREG: begin
                dp.writenum = w_rd;
                dp.vsel     = VSEL_C;
                dp.write    = 1'b1;
                w_next      = S_WAIT;
            end

            default: begin
                w_next = S_WAIT;
            end
        endcase
    end

endmodule : cpu_controller
